// File: rtl/fb_sram_scheduler.sv
// Frame-buffer SRAM scheduler: VGA line prefetch, pixel writes, page flip.
// One SRAM access per cycle; flips apply only in IDLE.
module fb_sram_scheduler #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int PAGE_OFFSET = 307200
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_req,
  input  logic [9:0]  line_y,
  output logic        line_done,
  input  logic        vsync_start,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [3:0]  wr_color,
  input  logic        flip_req,
  output logic        flip_ack,
  output logic        page_sel,
  output logic [9:0]  fifo_address,
  output logic [3:0]  fifo_data,
  output logic        fifo_we,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {
    IDLE,
    LINE_RD,
    WRITE
  } state_t;

  localparam logic [9:0] HP    = 10'(H_PIXELS);
  localparam logic [9:0] HP_M1 = 10'(H_PIXELS - 1);
  localparam logic [9:0] VL    = 10'(V_LINES);

  state_t     state, state_nx;
  logic [9:0] x_q, y_q, lat_y;
  logic [9:0] wx_q, wy_q;
  logic [3:0] wc_q;
  logic       line_pend, flip_pend;
  logic       line_ok, take_flip, take_line;
  logic       take_wr, last_px, wr_ok;
  logic       dq_oe;

  function automatic logic [19:0] addr_of(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic       pg
  );
    logic [19:0] a;
    a = 20'(y) * 20'(H_PIXELS) + 20'(x);
    if (pg) a = a + 20'(PAGE_OFFSET);
    return a;
  endfunction

  assign line_ok   = line_req && (line_y < VL);
  // a same-cycle valid line request also blocks the write
  assign wr_ready  = (state == IDLE) && !flip_pend
                  && !line_pend && !line_ok;
  assign take_flip = (state == IDLE) && flip_pend;
  assign take_line = (state == IDLE) && !flip_pend
                  && line_pend;
  assign take_wr   = wr_valid && wr_ready;
  assign last_px   = (state == LINE_RD) && (x_q == HP_M1);
  assign wr_ok     = (wx_q < HP) && (wy_q < VL);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? {12'h000, wc_q} : 16'hzzzz;

  always_comb begin
    state_nx  = state;
    SRAM_ADDR = 20'd0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_line)    state_nx = LINE_RD;
        else if (take_wr) state_nx = WRITE;
      end
      LINE_RD: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = addr_of(x_q, y_q, ~page_sel);
        if (last_px) state_nx = IDLE;
      end
      WRITE: begin
        SRAM_ADDR = addr_of(wx_q, wy_q, page_sel);
        SRAM_WE_N = ~wr_ok;
        dq_oe     = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      page_sel     <= 1'b0;
      line_pend    <= 1'b0;
      flip_pend    <= 1'b0;
      lat_y        <= 10'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      wx_q         <= 10'd0;
      wy_q         <= 10'd0;
      wc_q         <= 4'd0;
      fifo_we      <= 1'b0;
      fifo_address <= 10'd0;
      fifo_data    <= 4'd0;
      line_done    <= 1'b0;
      flip_ack     <= 1'b0;
    end else begin
      state     <= state_nx;
      line_pend <= (line_pend && !take_line) || line_ok;
      flip_pend <= (flip_pend && !take_flip)
                || (vsync_start && flip_req);
      flip_ack  <= take_flip;
      if (line_ok) lat_y <= line_y;
      if (take_flip) page_sel <= ~page_sel;
      if (take_line) begin
        x_q <= 10'd0;
        y_q <= lat_y;
      end else if (state == LINE_RD) begin
        x_q <= x_q + 10'd1;
      end
      if (take_wr) begin
        wx_q <= wr_x;
        wy_q <= wr_y;
        wc_q <= wr_color;
      end
      fifo_we   <= (state == LINE_RD);
      line_done <= last_px;
      if (state == LINE_RD) begin
        fifo_address <= x_q;
        fifo_data    <= SRAM_DQ[3:0];
      end
    end
  end

endmodule

// File: tb/tb_fb_sram_scheduler.sv
// Directed bench for fb_sram_scheduler with a behavioural SRAM read model.
// Read data is {12'h0, addr[3:0]^4'h5}.
module tb_fb_sram_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        line_req, vsync_start, wr_valid, flip_req;
  logic [9:0]  line_y, wr_x, wr_y;
  logic [3:0]  wr_color;
  logic        line_done, wr_ready, flip_ack, page_sel;
  logic [9:0]  fifo_address;
  logic [3:0]  fifo_data;
  logic        fifo_we;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N;
  logic        SRAM_LB_N, SRAM_UB_N;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N)
                 ? {12'h000, SRAM_ADDR[3:0] ^ 4'h5}
                 : 16'hzzzz;

  fb_sram_scheduler dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .line_req     (line_req),
    .line_y       (line_y),
    .line_done    (line_done),
    .vsync_start  (vsync_start),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .flip_req     (flip_req),
    .flip_ack     (flip_ack),
    .page_sel     (page_sel),
    .fifo_address (fifo_address),
    .fifo_data    (fifo_data),
    .fifo_we      (fifo_we),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_DQ      (SRAM_DQ),
    .SRAM_WE_N    (SRAM_WE_N),
    .SRAM_OE_N    (SRAM_OE_N),
    .SRAM_CE_N    (SRAM_CE_N),
    .SRAM_LB_N    (SRAM_LB_N),
    .SRAM_UB_N    (SRAM_UB_N)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [3:0] rd_val(input int a);
    logic [31:0] v;
    v = a;
    return v[3:0] ^ 4'h5;
  endfunction

  task automatic run_line(input int y, input int base,
                          input bit vs);
    line_req = 1'b1;
    line_y   = 10'(y);
    #1;
    chk("line_blocks_wr", 32'(wr_ready), 0);
    cyc();
    line_req = 1'b0;
    chk("pend_wr_ready", 32'(wr_ready), 0);
    chk("pend_oe", 32'(SRAM_OE_N), 1);
    cyc();
    for (int i = 0; i < 640; i++) begin
      chk("rd_addr", 32'(SRAM_ADDR), base + i);
      chk("rd_oe", 32'(SRAM_OE_N), 0);
      chk("rd_we", 32'(SRAM_WE_N), 1);
      chk("rd_wr_ready", 32'(wr_ready), 0);
      chk("rd_done", 32'(line_done), 0);
      if (i == 0) begin
        chk("rd_fifo_we0", 32'(fifo_we), 0);
      end else begin
        chk("rd_fifo_we", 32'(fifo_we), 1);
        chk("rd_fifo_addr", 32'(fifo_address), i - 1);
        chk("rd_fifo_data", 32'(fifo_data),
            32'(rd_val(base + i - 1)));
      end
      vsync_start = vs && (i == 300);
      if (vs && i == 300) flip_req = 1'b1;
      cyc();
    end
    vsync_start = 1'b0;
    chk("last_fifo_we", 32'(fifo_we), 1);
    chk("last_fifo_addr", 32'(fifo_address), 639);
    chk("last_fifo_data", 32'(fifo_data),
        32'(rd_val(base + 639)));
    chk("line_done", 32'(line_done), 1);
    chk("post_oe", 32'(SRAM_OE_N), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n     = 1'b0;
    line_req    = 1'b0;
    line_y      = '0;
    vsync_start = 1'b0;
    wr_valid    = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    wr_color    = '0;
    flip_req    = 1'b0;
    #1;
    chk("rst_page", 32'(page_sel), 0);
    chk("rst_we_n", 32'(SRAM_WE_N), 1);
    chk("rst_oe_n", 32'(SRAM_OE_N), 1);
    chk("rst_ce_n", 32'(SRAM_CE_N), 0);
    chk("rst_lb_n", 32'(SRAM_LB_N), 0);
    chk("rst_ub_n", 32'(SRAM_UB_N), 0);
    chk("rst_addr", 32'(SRAM_ADDR), 0);
    chk("rst_fifo_we", 32'(fifo_we), 0);
    chk("rst_fifo_addr", 32'(fifo_address), 0);
    chk("rst_fifo_data", 32'(fifo_data), 0);
    chk("rst_done", 32'(line_done), 0);
    chk("rst_ack", 32'(flip_ack), 0);
    cyc();
    cyc();
    Reset_n = 1'b1;

    // write (5,2) colour 7 to page 0
    wr_valid = 1'b1;
    wr_x = 10'd5; wr_y = 10'd2; wr_color = 4'd7;
    #1;
    chk("t1_ready", 32'(wr_ready), 1);
    cyc();
    wr_valid = 1'b0;
    chk("t1_addr", 32'(SRAM_ADDR), 1285);
    chk("t1_we_n", 32'(SRAM_WE_N), 0);
    chk("t1_oe_n", 32'(SRAM_OE_N), 1);
    chk("t1_dq", 32'(SRAM_DQ), 32'h7);
    chk("t1_busy", 32'(wr_ready), 0);
    cyc();
    chk("t1_idle_we", 32'(SRAM_WE_N), 1);

    // write held across a line of y=1 from display page 1
    wr_valid = 1'b1;
    wr_x = 10'd3; wr_y = 10'd4; wr_color = 4'd9;
    run_line(1, 307840, 1'b0);
    chk("t3_ready_after", 32'(wr_ready), 1);
    cyc();
    wr_valid = 1'b0;
    chk("t3_addr", 32'(SRAM_ADDR), 2563);
    chk("t3_we_n", 32'(SRAM_WE_N), 0);
    chk("t3_dq", 32'(SRAM_DQ), 32'h9);
    chk("t3_done_clr", 32'(line_done), 0);
    cyc();

    // flip requested at vsync during a line
    run_line(5, 310400, 1'b1);
    chk("t4_ready_pend", 32'(wr_ready), 0);
    chk("t4_ack_early", 32'(flip_ack), 0);
    chk("t4_page_early", 32'(page_sel), 0);
    cyc();
    chk("t4_ack", 32'(flip_ack), 1);
    chk("t4_page", 32'(page_sel), 1);
    flip_req = 1'b0;
    wr_valid = 1'b1;
    wr_x = 10'd0; wr_y = 10'd0; wr_color = 4'd3;
    #1;
    chk("t4_ready", 32'(wr_ready), 1);
    cyc();
    wr_valid = 1'b0;
    chk("t4_addr", 32'(SRAM_ADDR), 307200);
    chk("t4_we_n", 32'(SRAM_WE_N), 0);
    chk("t4_ack_pulse", 32'(flip_ack), 0);
    cyc();

    // reset mid-line at x=300, display page 0
    line_req = 1'b1;
    line_y   = 10'd2;
    cyc();
    line_req = 1'b0;
    cyc();
    repeat (300) cyc();
    chk("t5_addr300", 32'(SRAM_ADDR), 1580);
    Reset_n = 1'b0;
    #1;
    chk("t5_fifo_we", 32'(fifo_we), 0);
    chk("t5_done", 32'(line_done), 0);
    chk("t5_page", 32'(page_sel), 0);
    chk("t5_oe_n", 32'(SRAM_OE_N), 1);
    chk("t5_addr", 32'(SRAM_ADDR), 0);
    cyc();
    Reset_n = 1'b1;
    #1;
    chk("t5_pend_clr", 32'(wr_ready), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_done", 32'(line_done), 0);
      chk("t5_no_we", 32'(fifo_we), 0);
      chk("t5_no_oe", 32'(SRAM_OE_N), 1);
    end

    // out-of-range write and line request
    wr_valid = 1'b1;
    wr_x = 10'd640; wr_y = 10'd0; wr_color = 4'd1;
    #1;
    chk("t6_ready", 32'(wr_ready), 1);
    cyc();
    wr_valid = 1'b0;
    chk("t6_addr", 32'(SRAM_ADDR), 640);
    chk("t6_we_n", 32'(SRAM_WE_N), 1);
    chk("t6_busy", 32'(wr_ready), 0);
    cyc();
    line_req = 1'b1;
    line_y   = 10'd480;
    #1;
    chk("t6_line_ign0", 32'(wr_ready), 1);
    cyc();
    line_req = 1'b0;
    chk("t6_line_ign1", 32'(wr_ready), 1);
    cyc();
    chk("t6_line_oe", 32'(SRAM_OE_N), 1);
    chk("t6_line_ign2", 32'(wr_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
